// File: rtl/axis_effect_controller.sv
// axis_effect_controller: ramps gain/clip thresholds toward switch target, committed atomically per packet (CLIP_TOGGLE_EN selects toggle-mode clip button); ports clk/reset, sw/btn/frame_tick in, gain/thresh_hi/thresh_lo/clip_en/cfg_update/busy out
module axis_effect_controller #(
  parameter int          SWITCH_WIDTH    = 4,
  parameter int          DEBOUNCE_CYCLES = 1000000,
  parameter logic [23:0] RAMP_STEP       = 24'h010000,
  parameter logic [23:0] CLIP_LEVEL      = 24'h3C0000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [SWITCH_WIDTH-1:0] sw,
  input  logic                    btn,
  input  logic                    frame_tick,
  output logic [24:0]             gain,
  output logic [23:0]             thresh_hi,
  output logic [23:0]             thresh_lo,
  output logic                    clip_en,
  output logic                    cfg_update,
  output logic                    busy
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  typedef enum logic {IDLE, RAMP} state_t;
  state_t state, state_n;
  logic [SWITCH_WIDTH-1:0] sw_m, sw_t, sw_s;
  logic [1:0] btn_sy;
  logic [CW-1:0] cnt;
  logic btn_db, clip_src, db_hit;
  logic p1, clip_r, land_r;
  logic [24:0] gn_r, target, gain_step;
  logic [25:0] up_sum;
  logic [23:0] th;
  logic accept;
  always_ff @(posedge clk) {sw_s, sw_t, sw_m} <= {sw_t, sw_m, sw};
  assign db_hit = (btn_sy[1] != btn_db) && (cnt == CW'(DEBOUNCE_CYCLES - 1));
  always_ff @(posedge clk) begin
    if (reset) begin
      btn_sy <= '0;
      cnt    <= '0;
      btn_db <= 1'b0;
    end else begin
      btn_sy <= {btn_sy[0], btn};
      cnt    <= (btn_sy[1] == btn_db || db_hit) ? '0 : cnt + 1'b1;
      if (db_hit) btn_db <= btn_sy[1];
    end
  end
`ifdef CLIP_TOGGLE_EN
  logic clip_state;
  always_ff @(posedge clk) begin
    if (reset) clip_state <= 1'b0;
    else if (db_hit && btn_sy[1]) clip_state <= !clip_state;
  end
  assign clip_src = clip_state;
`else
  assign clip_src = btn_db;
`endif
  assign target = &sw_s ? 25'h1000000 : 25'(sw_s) * 25'h111111;
  assign up_sum = {1'b0, gain} + {2'b0, RAMP_STEP};
  assign gain_step = (target > gain)
                   ? ((up_sum > {1'b0, target}) ? target : up_sum[24:0])
                   : ((gain - target <= {1'b0, RAMP_STEP}) ? target : gain - {1'b0, RAMP_STEP});
  // cfg_update marks the commit cycle, so it doubles as the second occupancy slot
  assign accept = frame_tick && !p1 && !cfg_update;
  assign th = 24'((49'(CLIP_LEVEL) * 49'(gn_r)) >> 24);
  always_ff @(posedge clk) begin
    if (reset) begin
      p1     <= 1'b0;
      gn_r   <= '0;
      clip_r <= 1'b0;
      land_r <= 1'b0;
    end else begin
      p1 <= accept;
      if (accept) begin
        gn_r   <= gain_step;
        clip_r <= clip_src;
        land_r <= gain_step == target;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      gain       <= '0;
      thresh_hi  <= '0;
      thresh_lo  <= '0;
      clip_en    <= 1'b0;
      cfg_update <= 1'b0;
    end else begin
      cfg_update <= p1;
      if (p1) begin
        gain      <= gn_r;
        thresh_hi <= th;
        thresh_lo <= ~th + 24'd1;
        clip_en   <= clip_r;
      end
    end
  end
  always_ff @(posedge clk) state <= reset ? IDLE : state_n;
  always_comb state_n = p1 ? (land_r ? IDLE : RAMP) : state;
  assign busy = state == RAMP;
endmodule

// File: tb/tb_axis_effect_controller.sv
// tb_axis_effect_controller: directed self-checking bench for axis_effect_controller
module tb_axis_effect_controller;
  logic clk = 1'b0, reset = 1'b1, btn = 1'b0, frame_tick = 1'b0;
  logic [3:0] sw = 4'hF;
  logic [24:0] gain;
  logic [23:0] thresh_hi, thresh_lo;
  logic clip_en, cfg_update, busy;
  logic exp_rel;
  int n_checks = 0, n_fail = 0;
  axis_effect_controller #(
    .SWITCH_WIDTH(4), .DEBOUNCE_CYCLES(4), .RAMP_STEP(24'h400000), .CLIP_LEVEL(24'h3C0000)
  ) dut (
    .clk(clk), .reset(reset), .sw(sw), .btn(btn), .frame_tick(frame_tick),
    .gain(gain), .thresh_hi(thresh_hi), .thresh_lo(thresh_lo),
    .clip_en(clip_en), .cfg_update(cfg_update), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic do_tick(input string tag, input logic [24:0] eg, input logic ec, input logic eb);
    logic [23:0] th;
    th = 24'((49'(24'h3C0000) * 49'(eg)) >> 24);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    @(negedge clk);
    check({tag, " cfg_update"}, 32'(cfg_update), 32'd1);
    check({tag, " gain"}, 32'(gain), 32'(eg));
    check({tag, " thresh_hi"}, 32'(thresh_hi), 32'(th));
    check({tag, " thresh_lo"}, 32'(thresh_lo), 32'(24'(-th)));
    check({tag, " clip_en"}, 32'(clip_en), 32'(ec));
    check({tag, " busy"}, 32'(busy), 32'(eb));
    cycles(6);
  endtask
  initial begin
    cycles(5);
    reset = 1'b0;
    cycles(1);
    check("rst gain", 32'(gain), 0);
    check("rst thresh_hi", 32'(thresh_hi), 0);
    check("rst thresh_lo", 32'(thresh_lo), 0);
    check("rst clip_en", 32'(clip_en), 0);
    check("rst cfg_update", 32'(cfg_update), 0);
    check("rst busy", 32'(busy), 0);
    do_tick("ss1", 25'h0400000, 1'b0, 1'b1);
    do_tick("ss2", 25'h0800000, 1'b0, 1'b1);
    do_tick("ss3", 25'h0C00000, 1'b0, 1'b1);
    do_tick("ss4", 25'h1000000, 1'b0, 1'b0);
    check("ss4 thresh_hi const", 32'(thresh_hi), 32'h3C0000);
    check("ss4 thresh_lo const", 32'(thresh_lo), 32'hC40000);
    sw = 4'h0;
    cycles(4);
    do_tick("rd1", 25'h0C00000, 1'b0, 1'b1);
    do_tick("rd2", 25'h0800000, 1'b0, 1'b1);
    sw = 4'h8;
    cycles(4);
    do_tick("rd3", 25'h0888888, 1'b0, 1'b0);
    check("rd3 thresh_hi const", 32'(thresh_hi), 32'h1FFFFF);
    do_tick("rd4", 25'h0888888, 1'b0, 1'b0);
    btn = 1'b1;
    cycles(3);
    btn = 1'b0;
    cycles(8);
    do_tick("db_short", 25'h0888888, 1'b0, 1'b0);
    btn = 1'b1;
    cycles(10);
    do_tick("db_held1", 25'h0888888, 1'b1, 1'b0);
    do_tick("db_held2", 25'h0888888, 1'b1, 1'b0);
    btn = 1'b0;
    cycles(10);
`ifdef CLIP_TOGGLE_EN
    exp_rel = 1'b1;
`else
    exp_rel = 1'b0;
`endif
    do_tick("db_release", 25'h0888888, exp_rel, 1'b0);
`ifdef CLIP_TOGGLE_EN
    btn = 1'b1;
    cycles(10);
    btn = 1'b0;
    cycles(10);
    do_tick("db_toggle_off", 25'h0888888, 1'b0, 1'b0);
`endif
    sw = 4'h0;
    cycles(4);
    frame_tick = 1'b1;
    cycles(2);
    frame_tick = 1'b0;
    check("sp first cfg_update", 32'(cfg_update), 1);
    check("sp first gain", 32'(gain), 32'h488888);
    @(negedge clk);
    check("sp drop cfg_update", 32'(cfg_update), 0);
    check("sp drop gain", 32'(gain), 32'h488888);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    check("sp n3 wait cfg_update", 32'(cfg_update), 0);
    @(negedge clk);
    check("sp n3 cfg_update", 32'(cfg_update), 1);
    check("sp n3 gain", 32'(gain), 32'h088888);
    check("sp n3 busy", 32'(busy), 1);
    cycles(6);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    @(negedge clk);
    check("n2 first cfg_update", 32'(cfg_update), 1);
    check("n2 first gain", 32'(gain), 0);
    check("n2 first busy", 32'(busy), 0);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    check("n2 drop cfg_update a", 32'(cfg_update), 0);
    @(negedge clk);
    check("n2 drop cfg_update b", 32'(cfg_update), 0);
    cycles(6);
    sw = 4'hF;
    cycles(4);
    do_tick("rr1", 25'h0400000, 1'b0, 1'b1);
    do_tick("rr2", 25'h0800000, 1'b0, 1'b1);
    reset = 1'b1;
    frame_tick = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    frame_tick = 1'b0;
    check("rr rst gain", 32'(gain), 0);
    check("rr rst thresh_hi", 32'(thresh_hi), 0);
    check("rr rst thresh_lo", 32'(thresh_lo), 0);
    check("rr rst clip_en", 32'(clip_en), 0);
    check("rr rst cfg_update", 32'(cfg_update), 0);
    check("rr rst busy", 32'(busy), 0);
    cycles(3);
    check("rr no commit cfg_update", 32'(cfg_update), 0);
    check("rr no commit gain", 32'(gain), 0);
    cycles(3);
    do_tick("rr3", 25'h0400000, 1'b0, 1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/axis_effect_controller.md
# axis_effect_controller

Configuration sequencer for the AXI-Stream volume/clipping datapath. It synchronizes the switch bank and debounces the clip button, then ramps the volume multiplier toward the switch-selected target in fixed steps, one step per audio packet. It derives the matching scaled clip thresholds and presents gain, thresholds and clip enable as one coherent set. All outputs change only on a packet boundary, so the datapath never processes a stereo pair with mixed settings.

## Interface
Parameters:
- SWITCH_WIDTH, 4: switch bank width; only 4 is supported.
- DEBOUNCE_CYCLES, 1000000: cycles the button must be stable before it is accepted (10 ms at 100 MHz).
- RAMP_STEP, 24'h010000: maximum gain change per packet.
- CLIP_LEVEL, 24'h3C0000: unscaled positive clip threshold. Must be less than 2^23.

Ports:
- clk  in  1  system clock. One clock only; synchronous, active-high reset.
- reset  in  1  synchronous active-high reset.
- sw  in  SWITCH_WIDTH  asynchronous volume switches.
- btn  in  1  asynchronous clip button.
- frame_tick  in  1  one-cycle pulse when the datapath accepts the last word of a stereo packet.
- gain  out  25  unsigned multiplier; 0x1000000 = 1.0.
- thresh_hi  out  24  signed positive clip threshold after scaling.
- thresh_lo  out  24  two's-complement negation of thresh_hi.
- clip_en  out  1  clipping enable.
- cfg_update  out  1  one-cycle pulse when the output set changes.
- busy  out  1  high while ramping.

## Operation
- **Switch sync:** sw passes through a 3-flop synchronizer to give sw_s.
- **Target gain:**
  - target = sw_s × 0x111111 for sw_s < 4'hF.
  - target = 0x1000000 for sw_s = 4'hF.
  - target is re-evaluated on every frame_tick.
- **Button debounce:**
  - btn passes through a 2-flop synchronizer.
  - The debounced value btn_db takes the new level only after the synchronized button differs from btn_db for DEBOUNCE_CYCLES consecutive cycles.
  - Any match before that clears the counter.
- **FSM states:**
  - IDLE: gain equals target.
  - RAMP: gain differs from target; busy = 1.
- **FSM transitions (evaluated at a tick):**
  - IDLE→RAMP when target ≠ gain.
  - RAMP→IDLE when the step lands exactly on target.
  - The ramp direction follows sign(target − gain) at each tick, so switch changes mid-ramp simply redirect it.
- **Ramp step:**
  - Up: gain_next = min(gain + RAMP_STEP, target).
  - Down: gain_next = max(gain − RAMP_STEP, target).
  - Never overshoot the target.
- **Thresholds:**
  - thresh_hi = (CLIP_LEVEL × gain_next) >> 24, truncated. This always fits in 24 bits because gain ≤ 2^24.
  - thresh_lo = ~thresh_hi + 1.
- **clip_en** is sampled from btn_db at the tick and committed with the rest of the set.

## Timing
- **Pipeline:**
  - Tick at cycle N.
  - Cycle N+1: gain_next and sampled clip value registered.
  - Cycle N+2: gain, thresh_hi, thresh_lo and clip_en all update together; cfg_update = 1 for that cycle.
- **cfg_update** pulses on every committed tick, even if the values are unchanged.
- **busy** reflects the FSM state after the N+2 commit.
- **Tick spacing:**
  - A frame_tick at N+1 or N+2 (pipeline occupied) is dropped with no effect.
  - A tick at N+3 is accepted.
- **Reset values:**
  - gain = 0, thresh_hi = 0, thresh_lo = 0, clip_en = 0, cfg_update = 0, busy = 0.
  - FSM = IDLE, debounce counter = 0, btn_db = 0, pipeline empty.
- **After reset:** gain soft-starts from 0 toward the target.
- **Reset mid-operation:**
  - Reset has priority over frame_tick in the same cycle.
  - A pending pipeline commit is discarded.
  - Outputs are at reset values one cycle after reset is asserted.
- **Not covered by reset:** the switch synchronizer flops; their contents flush within 3 cycles.

## Configuration
- `CLIP_TOGGLE_EN` defined: each rising edge of btn_db toggles an internal clip_state. clip_en commits clip_state at the next tick.
- Undefined: clip_en commits the level of btn_db at the tick, so clipping is active only while the button is held. The toggle register is not built.

## Test plan
Bench parameters: DEBOUNCE_CYCLES = 4, RAMP_STEP = 0x400000, CLIP_LEVEL = 0x3C0000, ticks spaced ≥ 8 cycles.

1. **Soft start.** Reset, sw = 4'hF, 4 ticks → gain = 0x400000, 0x800000, 0xC00000, 0x1000000, each at tick+2. busy falls at the 4th commit. Final thresh_hi = 0x3C0000, thresh_lo = 0xC40000.
2. **Ramp down with redirect.** From gain 0x1000000, set sw = 0; tick, tick → 0xC00000, 0x800000. Then set sw = 4'h8 (target 0x888888), tick, tick → 0x888888, then IDLE with busy = 0.
3. **Debounce.**
   - btn high for 3 cycles then low, tick → clip_en stays 0.
   - btn held 10 cycles, tick → clip_en = 1 at tick+2.
   - With `CLIP_TOGGLE_EN`: release, press again, tick → clip_en = 0.
4. **Tick spacing.** While ramping, ticks at N and N+1 → exactly one step and one cfg_update pulse. A tick at N+3 → a second step.
5. **Reset mid-ramp.** Assert reset for 1 cycle at gain = 0x800000, coincident with a tick → all outputs 0 on the next cycle, no commit occurs, and the ramp restarts from 0.
6. **Macro undefined.** Hold btn through 2 ticks, then release before a 3rd → clip_en = 1, 1, 0 at the respective commits.
